// File: rtl/full_adder_monitor.sv
// ---------------------------------------------------------------------------
// full_adder_monitor
//
// Receive-side checker for a 1-bit full adder. Watches the stimulus driven
// into the adder (a, b, c_in) and the adder response (s, c_out). Each checked
// response is compared against the golden sum/carry. The block counts
// mismatches, records the first failing vector, and tracks coverage of the
// 8 input vectors. It reports done/pass once every vector has been checked.
// The block is synthesizable, so it can also serve as an on-chip BIST
// response checker.
//
// Optional feature (define FA_MON_TIMEOUT_EN):
//   RUN is abandoned after TIMEOUT_CYC cycles without new coverage. The FSM
//   then enters DONE with timeout=1. Without the macro, timeout is tied to 0
//   and RUN waits indefinitely.
//
// Parameters
//   LAT          adder latency from stimulus to response, in cycles (0..4)
//   ERR_CNT_W    width of the saturating mismatch counter
//   TIMEOUT_CYC  RUN cycles allowed without new coverage (timeout build only)
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   start          in   pulse: clear all results and enter RUN
//   vld            in   a/b/c_in carry a valid stimulus this cycle
//   a, b, c_in     in   stimulus applied to the adder
//   s, c_out       in   adder response, valid LAT cycles after vld
//   busy           out  FSM is in RUN
//   done           out  FSM is in DONE
//   pass           out  done with no mismatches and no timeout
//   err_cnt        out  mismatch count, saturates at all-ones
//   cov_map        out  bit i set = vector {b,a,c_in}==i has been checked
//   first_err_vld  out  a mismatch has been captured
//   first_err_vec  out  vector index of the first mismatch
//   timeout        out  RUN ended by timeout
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset; vld ignored, waiting for start
// RUN     | checking delayed samples, accumulating coverage/errors
// DONE    | coverage complete (or timed out); results held until start
// ---------------------------------------------------------------------------
module full_adder_monitor #(
    parameter int LAT         = 0,
    parameter int ERR_CNT_W   = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 vld,
    input  logic                 a,
    input  logic                 b,
    input  logic                 c_in,
    input  logic                 s,
    input  logic                 c_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [7:0]           cov_map,
    output logic                 first_err_vld,
    output logic [2:0]           first_err_vec,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    if (LAT < 0 || LAT > 4) begin : g_lat_chk
        $error("full_adder_monitor: LAT must be in 0..4");
    end
    if (TIMEOUT_CYC < 1) begin : g_tmo_chk
        $error("full_adder_monitor: TIMEOUT_CYC must be at least 1");
    end

    state_t state, state_nxt;

    logic [2:0] idx;
    logic       chk_vld;
    logic [2:0] chk_idx;

    assign idx = {b, a, c_in};

    // Delay line aligning the stimulus with the adder response. start
    // flushes it so samples from a previous run never leak into a new one.
    if (LAT == 0) begin : g_nodly
        assign chk_vld = vld;
        assign chk_idx = idx;
    end else begin : g_dly
        logic [LAT-1:0]      dly_vld;
        logic [LAT-1:0][2:0] dly_idx;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dly_vld <= '0;
                dly_idx <= '0;
            end else if (start) begin
                dly_vld <= '0;
                dly_idx <= '0;
            end else begin
                dly_vld[0] <= vld;
                dly_idx[0] <= idx;
                for (int i = 1; i < LAT; i++) begin
                    dly_vld[i] <= dly_vld[i-1];
                    dly_idx[i] <= dly_idx[i-1];
                end
            end
        end

        assign chk_vld = dly_vld[LAT-1];
        assign chk_idx = dly_idx[LAT-1];
    end

    // Golden response for the delayed vector.
    logic exp_s, exp_c, mismatch;

    assign exp_s    = chk_idx[2] ^ chk_idx[1] ^ chk_idx[0];
    assign exp_c    = (chk_idx[2] & chk_idx[1]) | (chk_idx[1] & chk_idx[0]) |
                      (chk_idx[2] & chk_idx[0]);
    assign mismatch = ({s, c_out} != {exp_s, exp_c});

    logic [ERR_CNT_W-1:0] err_nxt;
    logic [7:0]           cov_nxt;
    logic                 fev_nxt;
    logic [2:0]           fvec_nxt;

`ifdef FA_MON_TIMEOUT_EN
    // Down-counter reloaded on start and on every new coverage bit; a
    // terminal count of zero in a cycle without new coverage ends the run.
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic             tmo_nxt;
    logic             new_cov;
`endif

    always_comb begin
        state_nxt = state;
        err_nxt   = err_cnt;
        cov_nxt   = cov_map;
        fev_nxt   = first_err_vld;
        fvec_nxt  = first_err_vec;
`ifdef FA_MON_TIMEOUT_EN
        tmo_nxt     = timeout;
        tmo_cnt_nxt = tmo_cnt;
        new_cov     = 1'b0;
`endif
        if (start) begin
            state_nxt = ST_RUN;
            err_nxt   = '0;
            cov_nxt   = '0;
            fev_nxt   = 1'b0;
            fvec_nxt  = '0;
`ifdef FA_MON_TIMEOUT_EN
            tmo_nxt     = 1'b0;
            tmo_cnt_nxt = TMO_LOAD;
`endif
        end else if (state == ST_RUN) begin
            if (chk_vld) begin
                cov_nxt = cov_map | (8'd1 << chk_idx);
`ifdef FA_MON_TIMEOUT_EN
                new_cov = ~cov_map[chk_idx];
`endif
                if (mismatch) begin
                    if (err_cnt != '1) begin
                        err_nxt = err_cnt + 1'b1;
                    end
                    if (!first_err_vld) begin
                        fev_nxt  = 1'b1;
                        fvec_nxt = chk_idx;
                    end
                end
            end
            // Completing coverage takes precedence over a same-edge timeout.
            if (cov_nxt == 8'hFF) begin
                state_nxt = ST_DONE;
            end
`ifdef FA_MON_TIMEOUT_EN
            else if (!new_cov && (tmo_cnt == '0)) begin
                state_nxt = ST_DONE;
                tmo_nxt   = 1'b1;
            end
            if (new_cov) begin
                tmo_cnt_nxt = TMO_LOAD;
            end else if (tmo_cnt != '0) begin
                tmo_cnt_nxt = tmo_cnt - 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt       <= '0;
            cov_map       <= '0;
            first_err_vld <= 1'b0;
            first_err_vec <= '0;
        end else begin
            err_cnt       <= err_nxt;
            cov_map       <= cov_nxt;
            first_err_vld <= fev_nxt;
            first_err_vec <= fvec_nxt;
        end
    end

`ifdef FA_MON_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            timeout <= tmo_nxt;
            tmo_cnt <= tmo_cnt_nxt;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign pass = done && (err_cnt == '0) && !timeout;

endmodule

// File: tb/tb_full_adder_monitor.sv
module tb_full_adder_monitor;

    localparam int TMO0 = 16;
    localparam int TMO1 = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic vld = 1'b0;
    logic a = 1'b0, b = 1'b0, c_in = 1'b0;
    logic inv_s = 1'b0, stuck_c = 1'b0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in adder with fault injection; unit 1 sees it through 2 stages.
    logic s0, c0;
    logic [1:0] r1 = 2'b00, r2 = 2'b00;
    assign s0 = (a ^ b ^ c_in) ^ inv_s;
    assign c0 = stuck_c ? 1'b0 : ((a & b) | (a & c_in) | (b & c_in));
    always @(posedge clk) begin
        r1 <= {s0, c0};
        r2 <= r1;
    end

    logic       busy0, done0, pass0, fev0, tmo0;
    logic [7:0] err0, cov0;
    logic [2:0] fvec0;
    logic       busy1, done1, pass1, fev1, tmo1;
    logic [1:0] err1;
    logic [7:0] cov1;
    logic [2:0] fvec1;

    full_adder_monitor #(.LAT(0), .ERR_CNT_W(8), .TIMEOUT_CYC(TMO0)) u_mon0 (
        .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
        .a(a), .b(b), .c_in(c_in), .s(s0), .c_out(c0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .cov_map(cov0), .first_err_vld(fev0), .first_err_vec(fvec0),
        .timeout(tmo0)
    );

    full_adder_monitor #(.LAT(2), .ERR_CNT_W(2), .TIMEOUT_CYC(TMO1)) u_mon1 (
        .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
        .a(a), .b(b), .c_in(c_in), .s(r2[1]), .c_out(r2[0]),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .cov_map(cov1), .first_err_vld(fev1), .first_err_vec(fvec1),
        .timeout(tmo1)
    );

    typedef struct {
        int         err;
        logic [7:0] cov;
        logic       fev;
        logic [2:0] fvec;
        logic       pass;
        logic       tmo;
        int         cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: per-run sample list semantics, one entry per unit.
    int         lat_of[2] = '{0, 2};
    int         max_of[2] = '{255, 3};
    int         m_err[2];
    logic [7:0] m_cov[2];
    logic       m_fev[2];
    logic [2:0] m_fvec[2];
    bit         m_act[2];
    int         m_last_new[2];

    function automatic void chk(string nm, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic void feed(int k, logic [2:0] idx, bit is, bit sc);
        int sum, es, ec, gs, gc;
        exp_t e;
        if (!m_act[k]) return;
        sum = int'(idx[0]) + int'(idx[1]) + int'(idx[2]);
        es  = sum % 2;
        ec  = sum / 2;
        gs  = is ? (1 - es) : es;
        gc  = sc ? 0 : ec;
        if (!m_cov[k][idx]) m_last_new[k] = cyc + lat_of[k] + 1;
        m_cov[k][idx] = 1'b1;
        if (gs != es || gc != ec) begin
            if (m_err[k] < max_of[k]) m_err[k]++;
            if (!m_fev[k]) begin
                m_fev[k]  = 1'b1;
                m_fvec[k] = idx;
            end
        end
        if (m_cov[k] == 8'hFF) begin
            e.err  = m_err[k];
            e.cov  = 8'hFF;
            e.fev  = m_fev[k];
            e.fvec = m_fvec[k];
            e.pass = (m_err[k] == 0);
            e.tmo  = 1'b0;
            e.cyc  = cyc + lat_of[k] + 1;
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
            m_act[k] = 1'b0;
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 0; m_cov[k] = '0; m_fev[k] = 1'b0; m_fvec[k] = '0;
            m_act[k] = 1'b1; m_last_new[k] = cyc;
        end
    endfunction

    function automatic void check_done(string p, exp_t e, int err, int cov, int fev,
                                       int fvec, int ps, int tmo, int bsy);
        chk({p, "_done_cycle"}, cyc, e.cyc);
        chk({p, "_err_cnt"}, err, e.err);
        chk({p, "_cov_map"}, cov, int'(e.cov));
        chk({p, "_first_err_vld"}, fev, int'(e.fev));
        chk({p, "_first_err_vec"}, fvec, int'(e.fvec));
        chk({p, "_pass"}, ps, int'(e.pass));
        chk({p, "_timeout"}, tmo, int'(e.tmo));
        chk({p, "_busy_at_done"}, bsy, 0);
    endfunction

    logic done0_q = 1'b0, done1_q = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (done0 && !done0_q) begin
            if (q0.size() == 0) chk("d0_unexpected_done", 1, 0);
            else begin
                e = q0.pop_front();
                check_done("d0", e, int'(err0), int'(cov0), int'(fev0), int'(fvec0),
                           int'(pass0), int'(tmo0), int'(busy0));
            end
        end
        done0_q = done0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (done1 && !done1_q) begin
            if (q1.size() == 0) chk("d1_unexpected_done", 1, 0);
            else begin
                e = q1.pop_front();
                check_done("d1", e, int'(err1), int'(cov1), int'(fev1), int'(fvec1),
                           int'(pass1), int'(tmo1), int'(busy1));
            end
        end
        done1_q = done1;
    end

    function automatic void chk_zero(string p);
        chk({p, "_busy0"}, int'(busy0), 0);
        chk({p, "_done0"}, int'(done0), 0);
        chk({p, "_pass0"}, int'(pass0), 0);
        chk({p, "_err0"}, int'(err0), 0);
        chk({p, "_cov0"}, int'(cov0), 0);
        chk({p, "_fev0"}, int'(fev0), 0);
        chk({p, "_fvec0"}, int'(fvec0), 0);
        chk({p, "_tmo0"}, int'(tmo0), 0);
        chk({p, "_busy1"}, int'(busy1), 0);
        chk({p, "_done1"}, int'(done1), 0);
        chk({p, "_err1"}, int'(err1), 0);
        chk({p, "_cov1"}, int'(cov1), 0);
        chk({p, "_fev1"}, int'(fev1), 0);
    endfunction

    task automatic drive(bit v, logic [2:0] idx, bit is, bit sc);
        @(posedge clk);
        #1;
        vld = v;
        {b, a, c_in} = idx;
        inv_s = is;
        stuck_c = sc;
        if (v) begin
            feed(0, idx, is, sc);
            feed(1, idx, is, sc);
        end
    endtask

    task automatic do_start();
        @(posedge clk);
        #1;
        start = 1'b1; vld = 1'b0; inv_s = 1'b0; stuck_c = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        model_clear();
        chk("start_busy0", int'(busy0), 1);
        chk("start_busy1", int'(busy1), 1);
        chk("start_done0", int'(done0), 0);
        chk("start_err0", int'(err0), 0);
        chk("start_err1", int'(err1), 0);
        chk("start_cov0", int'(cov0), 0);
        chk("start_fev1", int'(fev1), 0);
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            chk("wait_done_budget", q0.size() + q1.size(), 0);
            q0.delete();
            q1.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int len, rot;
        logic [2:0] ix;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All 8 vectors, clean adder.
        do_start();
        for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 1'b0, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        wait_idle(50);

        // s inverted on vector 3.
        do_start();
        for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), (i == 3), 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        wait_idle(50);

        // Descending order with a bubble after vector 5.
        do_start();
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, 3'(i), 1'b0, 1'b0);
            if (i == 5) drive(1'b0, 3'd0, 1'b0, 1'b0);
        end
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        wait_idle(50);

        // c_out stuck at 0: 12 carry-producing samples, then the rest.
        do_start();
        for (int i = 0; i < 12; i++) begin
            case (i % 4)
                0: ix = 3'd3;
                1: ix = 3'd5;
                2: ix = 3'd6;
                default: ix = 3'd7;
            endcase
            drive(1'b1, ix, 1'b0, 1'b1);
        end
        chk("sat_err1_after_12", int'(err1), 3);
        drive(1'b1, 3'd0, 1'b0, 1'b1);
        drive(1'b1, 3'd1, 1'b0, 1'b1);
        drive(1'b1, 3'd2, 1'b0, 1'b1);
        drive(1'b1, 3'd4, 1'b0, 1'b1);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        wait_idle(50);
        chk("sat_err1_held", int'(err1), 3);

        // Randomized runs: short random prefix, then the remaining vectors.
        for (int r = 0; r < 6; r++) begin
            do_start();
            len = $urandom_range(4, 10);
            for (int j = 0; j < len; j++)
                drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            rot = $urandom_range(0, 7);
            for (int t = 0; t < 8; t++) begin
                ix = 3'((t + rot) % 8);
                if (m_act[0] && !m_cov[0][ix])
                    drive(1'b1, ix, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            end
            drive(1'b0, 3'd0, 1'b0, 1'b0);
            wait_idle(100);
        end

        // Mid-run reset: results lost, later vld ignored.
        do_start();
        for (int i = 0; i < 4; i++) drive(1'b1, 3'(i), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        vld = 1'b0;
        rst_n = 1'b0;
        m_act[0] = 1'b0;
        m_act[1] = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_zero("post_rst");
        chk("post_rst_no_done", q0.size() + q1.size(), 0);

`ifdef FA_MON_TIMEOUT_EN
        // Coverage stalls at 0..5; each unit gives up after its budget.
        do_start();
        for (int i = 0; i < 6; i++) drive(1'b1, 3'(i), 1'b0, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            e.err  = 0;
            e.cov  = 8'h3F;
            e.fev  = 1'b0;
            e.fvec = 3'd0;
            e.pass = 1'b0;
            e.tmo  = 1'b1;
            e.cyc  = m_last_new[k] + ((k == 0) ? TMO0 : TMO1);
            m_act[k] = 1'b0;
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        wait_idle(150);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
